// File: rtl/stream_mux_rr_pkg.sv
// Shared helpers for the stream_mux_rr slice: index arithmetic used by the arbiter.
package stream_mux_rr_pkg;

  // Channel index reached by stepping 'off' positions from 'base', wrapping at 'n'.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational grant logic: round-robin search from last+1, or lowest-index-wins.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter bit          ROUND_ROBIN = 1'b1,
  localparam int unsigned SEL_W      = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  int unsigned      start;
  logic [SEL_W-1:0] idx;

  // Walk the requests in priority order; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    start     = ROUND_ROBIN ? (int'(last) + 1) : 0;
    for (int unsigned off = 0; off < N_IN; off++) begin
      idx = SEL_W'(wrap_idx(start, off, N_IN));
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a single output register tagged by source channel.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned N_IN        = 4,
  parameter bit          ROUND_ROBIN = 1'b1,
  localparam int unsigned SEL_W      = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_valid,
  input  logic [WIDTH-1:0] in_data [N_IN],
  output logic [N_IN-1:0]  in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load;
  logic             accept;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;

  rr_arbiter #(
    .N_IN        (N_IN),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .req       (in_valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load   = !out_valid_q || out_ready;
  assign accept = load && gnt_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt_idx] = 1'b1;
  end

  // Register refills on pop-and-push in the same cycle, giving one beat per cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = in_data[gnt_idx];
        out_sel_d  = gnt_idx;
        last_d     = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench: round-robin, fixed-priority and 16-bit/3-channel instances on one clock.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=4, N_IN=4, round-robin
  logic       a_rst, a_out_ready, a_out_valid;
  logic [3:0] a_in_valid, a_in_ready, a_out_data;
  logic [3:0] a_in_data [4];
  logic [1:0] a_out_sel;

  stream_mux_rr #(.WIDTH(4), .N_IN(4), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_ready(a_out_ready)
  );

  // Instance B: WIDTH=4, N_IN=4, fixed priority
  logic       b_rst, b_out_ready, b_out_valid;
  logic [3:0] b_in_valid, b_in_ready, b_out_data;
  logic [3:0] b_in_data [4];
  logic [1:0] b_out_sel;

  stream_mux_rr #(.WIDTH(4), .N_IN(4), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready)
  );

  // Instance C: WIDTH=16, N_IN=3, round-robin
  logic        c_rst, c_out_ready, c_out_valid;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [15:0] c_in_data [3];
  logic [15:0] c_out_data;
  logic [1:0]  c_out_sel;

  stream_mux_rr #(.WIDTH(16), .N_IN(3), .ROUND_ROBIN(1'b1)) u_w (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_ready(c_out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_in_valid = 4'b1111; a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_in_data[i] = 4'(i + 8);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b0 || a_out_sel !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: in_ready=%b out_valid=%b out_sel=%0d, need 0000/0/0",
                 c, a_in_ready, a_out_valid, a_out_sel);
      end
    end
    a_rst = 1'b0;
    #1;
    total++;
    if (a_in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: in_ready=%b, need 0001", a_in_ready);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b1 || a_out_sel !== 2'd0 || a_out_data !== 4'd8) begin
      bad++;
      $display("FAIL reset_first_beat: valid=%b sel=%0d data=%0d, need 1/0/8",
               a_out_valid, a_out_sel, a_out_data);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_sel;
    logic [3:0] exp_rdy;
    for (int i = 1; i < 8; i++) begin
      exp_sel = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_sel;
      total++;
      if (a_in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rr_ready beat%0d: in_ready=%b, need %b", i, a_in_ready, exp_rdy);
      end
      tick();
      total++;
      if (a_out_valid !== 1'b1 || a_out_sel !== exp_sel || a_out_data !== 4'(exp_sel + 8)) begin
        bad++;
        $display("FAIL rr_beat%0d: valid=%b sel=%0d data=%0d, need 1/%0d/%0d",
                 i, a_out_valid, a_out_sel, a_out_data, exp_sel, exp_sel + 8);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    logic [1:0] exp_sel;
    a_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_sel = (i % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      total++;
      if (a_in_ready !== (4'b0001 << exp_sel)) begin
        bad++;
        $display("FAIL sparse_ready%0d: in_ready=%b, need %b", i, a_in_ready, 4'b0001 << exp_sel);
      end
      tick();
      total++;
      if (a_out_sel !== exp_sel || a_out_data !== 4'(exp_sel + 8)) begin
        bad++;
        $display("FAIL sparse_beat%0d: sel=%0d data=%0d, need %0d/%0d",
                 i, a_out_sel, a_out_data, exp_sel, exp_sel + 8);
      end
    end
  endtask

  task automatic test_backpressure();
    a_in_valid = 4'b1111; a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b1 || a_out_sel !== 2'd3 ||
          a_out_data !== 4'd11 || u_rr.last_q !== 2'd3) begin
        bad++;
        $display("FAIL stall cyc%0d: rdy=%b valid=%b sel=%0d data=%0d last=%0d, need 0000/1/3/11/3",
                 c, a_in_ready, a_out_valid, a_out_sel, a_out_data, u_rr.last_q);
      end
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL release_ready: in_ready=%b, need 0001", a_in_ready);
    end
    tick();
    total++;
    if (a_out_sel !== 2'd0 || a_out_data !== 4'd8) begin
      bad++;
      $display("FAIL release_beat0: sel=%0d data=%0d, need 0/8", a_out_sel, a_out_data);
    end
    tick();
    total++;
    if (a_out_sel !== 2'd1 || a_out_data !== 4'd9) begin
      bad++;
      $display("FAIL release_beat1: sel=%0d data=%0d, need 1/9", a_out_sel, a_out_data);
    end
    a_in_valid = 4'b0000;
    #1;
    total++;
    if (a_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL idle_ready: in_ready=%b, need 0000", a_in_ready);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b0 || a_out_sel !== 2'd1 || a_out_data !== 4'd9 || u_rr.last_q !== 2'd1) begin
      bad++;
      $display("FAIL idle_hold: valid=%b sel=%0d data=%0d last=%0d, need 0/1/9/1",
               a_out_valid, a_out_sel, a_out_data, u_rr.last_q);
    end
  endtask

  task automatic test_fixed_priority();
    b_rst = 1'b1; b_in_valid = 4'b0101; b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) b_in_data[i] = 4'(i + 8);
    tick();
    b_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (b_in_ready !== 4'b0001) begin
        bad++;
        $display("FAIL fp_ready cyc%0d: in_ready=%b, need 0001", c, b_in_ready);
      end
      tick();
      total++;
      if (b_out_valid !== 1'b1 || b_out_sel !== 2'd0 || b_out_data !== 4'd8) begin
        bad++;
        $display("FAIL fp_beat cyc%0d: valid=%b sel=%0d data=%0d, need 1/0/8",
                 c, b_out_valid, b_out_sel, b_out_data);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp_sel;
    c_rst = 1'b1; c_in_valid = 3'b000; c_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) c_in_data[i] = 16'h0000;
    tick();
    c_rst = 1'b0;
    c_in_valid = 3'b010; c_in_data[1] = 16'hBEEF;
    tick();
    total++;
    if (c_out_valid !== 1'b1 || c_out_sel !== 2'd1 || c_out_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL w_load: valid=%b sel=%0d data=%h, need 1/1/beef", c_out_valid, c_out_sel, c_out_data);
    end
    c_in_valid = 3'b111;
    for (int i = 0; i < 3; i++) c_in_data[i] = 16'(16'h1000 + i);
    c_out_ready = 1'b1;
    c_rst = 1'b1;
    #1;
    total++;
    if (c_in_ready !== 3'b000) begin
      bad++;
      $display("FAIL w_rst_ready: in_ready=%b, need 000", c_in_ready);
    end
    tick();
    total++;
    if (c_out_valid !== 1'b0 || c_out_data !== 16'h0000 || c_out_sel !== 2'd0) begin
      bad++;
      $display("FAIL w_rst_drop: valid=%b sel=%0d data=%h, need 0/0/0000", c_out_valid, c_out_sel, c_out_data);
    end
    c_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_sel = 2'(i % 3);
      tick();
      total++;
      if (c_out_valid !== 1'b1 || c_out_sel !== exp_sel || c_out_data !== 16'(16'h1000 + exp_sel)) begin
        bad++;
        $display("FAIL w_beat%0d: valid=%b sel=%0d data=%h, need 1/%0d/%h",
                 i, c_out_valid, c_out_sel, c_out_data, exp_sel, 16'h1000 + exp_sel);
      end
    end
  endtask

  initial begin
    a_rst = 1'b1; a_in_valid = '0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_in_valid = '0; b_out_ready = 1'b0;
    c_rst = 1'b1; c_in_valid = '0; c_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_data[i] = '0;
      b_in_data[i] = '0;
    end
    for (int i = 0; i < 3; i++) c_in_data[i] = '0;
    tick();
    test_reset();
    test_rr_fairness();
    test_sparse_wrap();
    test_backpressure();
    test_fixed_priority();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
